// File: rtl/mag_envelope_squelch_pkg.sv
// Shared definitions for mag_envelope_squelch.
//   - settings-bus addresses (defaults for the top-level parameters)
//   - squelch state encoding
//   - magnitude / envelope widths
//   - clamp_mag: signed-magnitude clamp applied to every input sample
package mag_envelope_squelch_pkg;

   localparam int MAG_W   = 16;  // magnitude and threshold width
   localparam int ENV_W   = 32;  // envelope, unsigned Q16.16
   localparam int CALC_W  = 34;  // signed working width of the IIR update
   localparam int ALPHA_W = 4;   // alpha_shift field width

   localparam logic [7:0] SR_OPEN_LEVEL_DEF  = 8'd194;
   localparam logic [7:0] SR_CLOSE_LEVEL_DEF = 8'd195;
   localparam logic [7:0] SR_HANG_DEF        = 8'd196;
   localparam logic [7:0] SR_CTRL_DEF        = 8'd197;

   typedef enum logic [1:0] {
      ST_CLOSED = 2'd0,
      ST_OPEN   = 2'd1,
      ST_HANG   = 2'd2
   } sq_state_t;

   // The magnitude arrives as a signed SC16 I component; anything negative
   // (including 0xFFFF) is treated as zero so the envelope never wraps.
   function automatic logic [MAG_W-1:0] clamp_mag(input logic [MAG_W-1:0] raw);
      return raw[MAG_W-1] ? '0 : raw;
   endfunction

endpackage

// File: rtl/mag_env_iir.sv
// One-pole IIR envelope update, purely combinational.
//   env          current envelope, unsigned Q16.16
//   mag          clamped magnitude, unsigned integer
//   alpha_shift  smoothing shift (0 = follow mag exactly)
//   env_next     env + ((mag<<16) - env) >>> alpha_shift, saturated to 32 bits
module mag_env_iir
   import mag_envelope_squelch_pkg::*;
(
   input  logic [ENV_W-1:0]   env,
   input  logic [MAG_W-1:0]   mag,
   input  logic [ALPHA_W-1:0] alpha_shift,
   output logic [ENV_W-1:0]   env_next
);

   logic signed [CALC_W-1:0] env_s;
   logic signed [CALC_W-1:0] target;
   logic signed [CALC_W-1:0] diff;
   logic signed [CALC_W-1:0] step;
   logic signed [CALC_W-1:0] sum;

   always_comb begin
      env_s  = $signed({2'b00, env});
      target = $signed({2'b00, mag, {(ENV_W-MAG_W){1'b0}}});
      diff   = target - env_s;
      // Arithmetic shift keeps the sign so a falling input decays the envelope.
      step   = diff >>> alpha_shift;
      sum    = env_s + step;
      // Clamp to the unsigned 32-bit range: negative -> 0, bit 32 set -> all ones.
      if (sum[CALC_W-1])
         env_next = '0;
      else if (sum[CALC_W-2])
         env_next = '1;
      else
         env_next = sum[ENV_W-1:0];
   end

endmodule

// File: rtl/setting_reg.sv
// Settings-bus register: captures in[] when strobe is high and addr matches.
//   clk, rst        clock, asynchronous active-high reset
//   strobe/addr/in  settings bus
//   out             registered value, AT_RESET after reset
module setting_reg #(
   parameter logic [7:0]       MY_ADDR  = 8'd0,
   parameter int               WIDTH    = 32,
   parameter logic [WIDTH-1:0] AT_RESET = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             strobe,
   input  logic [7:0]       addr,
   input  logic [WIDTH-1:0] in,
   output logic [WIDTH-1:0] out
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         out <= AT_RESET;
      else if (strobe && (addr == MY_ADDR))
         out <= in;
   end

endmodule

// File: rtl/mag_envelope_squelch.sv
// Envelope tracker and three-state squelch gate on an SC16 magnitude stream.
//   ce_clk, ce_rst                 clock, asynchronous active-high reset
//   set_stb/set_addr/set_data      settings bus (open, close, hang, ctrl)
//   i_tdata/i_tlast/i_tvalid/i_tready  input stream, magnitude in [31:16]
//   o_tdata/o_tlast/o_tvalid/o_tready  output stream, gated value in [31:16]
//   squelch_open                   gate is OPEN or HANG
//   env_level                      integer part of the envelope
module mag_envelope_squelch
   import mag_envelope_squelch_pkg::*;
#(
   parameter logic [7:0] SR_OPEN_LEVEL  = SR_OPEN_LEVEL_DEF,
   parameter logic [7:0] SR_CLOSE_LEVEL = SR_CLOSE_LEVEL_DEF,
   parameter logic [7:0] SR_HANG        = SR_HANG_DEF,
   parameter logic [7:0] SR_CTRL        = SR_CTRL_DEF
) (
   input  logic             ce_clk,
   input  logic             ce_rst,
   input  logic             set_stb,
   input  logic [7:0]       set_addr,
   input  logic [31:0]      set_data,
   input  logic [31:0]      i_tdata,
   input  logic             i_tlast,
   input  logic             i_tvalid,
   output logic             i_tready,
   output logic [31:0]      o_tdata,
   output logic             o_tlast,
   output logic             o_tvalid,
   input  logic             o_tready,
   output logic             squelch_open,
   output logic [MAG_W-1:0] env_level
);

   logic [MAG_W-1:0] open_level;
   logic [MAG_W-1:0] close_level;
   logic [MAG_W-1:0] hang_len;
   logic [4:0]       ctrl;

   setting_reg #(.MY_ADDR(SR_OPEN_LEVEL), .WIDTH(MAG_W)) sr_open (
      .clk(ce_clk), .rst(ce_rst), .strobe(set_stb), .addr(set_addr),
      .in(set_data[MAG_W-1:0]), .out(open_level));

   setting_reg #(.MY_ADDR(SR_CLOSE_LEVEL), .WIDTH(MAG_W)) sr_close (
      .clk(ce_clk), .rst(ce_rst), .strobe(set_stb), .addr(set_addr),
      .in(set_data[MAG_W-1:0]), .out(close_level));

   setting_reg #(.MY_ADDR(SR_HANG), .WIDTH(MAG_W)) sr_hang (
      .clk(ce_clk), .rst(ce_rst), .strobe(set_stb), .addr(set_addr),
      .in(set_data[MAG_W-1:0]), .out(hang_len));

   setting_reg #(.MY_ADDR(SR_CTRL), .WIDTH(5)) sr_ctrl (
      .clk(ce_clk), .rst(ce_rst), .strobe(set_stb), .addr(set_addr),
      .in(set_data[4:0]), .out(ctrl));

   // Upper settings bits and the Q half of the input carry no information here.
   logic unused_bits;
   assign unused_bits = ^{set_data[31:MAG_W], i_tdata[15:0]};

   logic [ALPHA_W-1:0] alpha_shift;
   logic               out_env;
   assign alpha_shift = ctrl[ALPHA_W-1:0];
   assign out_env     = ctrl[4];

   logic accept;
   assign i_tready = ~o_tvalid | o_tready;
   assign accept   = i_tvalid & i_tready;

   logic [MAG_W-1:0] mag;
   logic [ENV_W-1:0] env;
   logic [ENV_W-1:0] env_next;
   logic [MAG_W-1:0] env_int;

   assign mag = clamp_mag(i_tdata[31:16]);

   mag_env_iir u_iir (
      .env(env),
      .mag(mag),
      .alpha_shift(alpha_shift),
      .env_next(env_next)
   );

   // Thresholds compare against the envelope that includes this sample.
   assign env_int = env_next[ENV_W-1:ENV_W-MAG_W];

   sq_state_t        state;
   sq_state_t        state_next;
   logic [MAG_W-1:0] hang_cnt;
   logic [MAG_W-1:0] hang_next;
   logic [MAG_W-1:0] gated;

   // NOTE: every output of this block gets a default first, so no path can
   // leave a value unassigned and infer a latch.
   always_comb begin
      state_next = state;
      hang_next  = hang_cnt;
      gated      = '0;
      case (state)
         ST_CLOSED: begin
            if (env_int >= open_level)
               state_next = ST_OPEN;
         end
         ST_OPEN: begin
            if (env_int < close_level) begin
               state_next = ST_HANG;
               hang_next  = hang_len;
            end
         end
         ST_HANG: begin
            // Recovery above the close level wins over the timer expiring.
            if (env_int >= close_level)
               state_next = ST_OPEN;
            else if (hang_cnt == '0)
               state_next = ST_CLOSED;
            else
               hang_next = hang_cnt - 16'd1;
         end
         default: state_next = ST_CLOSED;
      endcase
      if (state_next != ST_CLOSED)
         gated = out_env ? env_int : mag;
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge ce_clk or posedge ce_rst) begin
      if (ce_rst) begin
         env          <= '0;
         state        <= ST_CLOSED;
         hang_cnt     <= '0;
         o_tdata      <= '0;
         o_tlast      <= 1'b0;
         o_tvalid     <= 1'b0;
         squelch_open <= 1'b0;
         env_level    <= '0;
      end else if (accept) begin
         env          <= env_next;
         state        <= state_next;
         hang_cnt     <= hang_next;
         o_tdata      <= {gated, 16'h0000};
         o_tlast      <= i_tlast;
         o_tvalid     <= 1'b1;
         squelch_open <= (state_next != ST_CLOSED);
         env_level    <= env_int;
      end else if (o_tready) begin
         o_tvalid     <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mag_envelope_squelch.sv
module tb_mag_envelope_squelch;

   logic        ce_clk = 1'b0;
   logic        ce_rst;
   logic        set_stb;
   logic [7:0]  set_addr;
   logic [31:0] set_data;
   logic [31:0] i_tdata;
   logic        i_tlast;
   logic        i_tvalid;
   logic        i_tready;
   logic [31:0] o_tdata;
   logic        o_tlast;
   logic        o_tvalid;
   logic        o_tready;
   logic        squelch_open;
   logic [15:0] env_level;

   mag_envelope_squelch dut (
      .ce_clk(ce_clk), .ce_rst(ce_rst),
      .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
      .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
      .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
      .squelch_open(squelch_open), .env_level(env_level)
   );

   always #5 ce_clk = ~ce_clk;

   localparam logic [7:0] A_OPEN = 8'd194, A_CLOSE = 8'd195, A_HANG = 8'd196, A_CTRL = 8'd197;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- reference model (spec rules, plain integer arithmetic)
   localparam int M_CLOSED = 0, M_OPEN = 1, M_HANG = 2;
   longint m_env;
   int     m_state, m_hang, m_open, m_close, m_hlen, m_alpha;
   bit     m_out_env;

   typedef struct {
      logic [31:0] data;
      logic        last;
      logic        open;
      logic [15:0] lvl;
   } beat_t;

   beat_t exp_q[$];

   task automatic model_reset();
      m_env = 0; m_state = M_CLOSED; m_hang = 0;
      m_open = 0; m_close = 0; m_hlen = 0; m_alpha = 0; m_out_env = 0;
   endtask

   task automatic model_set(input logic [7:0] addr, input logic [31:0] data);
      case (addr)
         A_OPEN:  m_open  = int'(data[15:0]);
         A_CLOSE: m_close = int'(data[15:0]);
         A_HANG:  m_hlen  = int'(data[15:0]);
         A_CTRL:  begin m_alpha = int'(data[3:0]); m_out_env = data[4]; end
         default: ;
      endcase
   endtask

   task automatic model_step(input logic [31:0] tdata, input logic last, output beat_t b);
      int m, e, outv;
      longint diff, div, step;
      logic [15:0] o16;
      m = $signed(tdata[31:16]);
      if (m < 0) m = 0;
      div  = longint'(1) << m_alpha;
      diff = longint'(m) * 65536 - m_env;
      // floor division, matching an arithmetic right shift
      if (diff >= 0) step = diff / div;
      else           step = -((-diff + div - 1) / div);
      m_env = m_env + step;
      if (m_env < 0) m_env = 0;
      if (m_env > 64'hFFFF_FFFF) m_env = 64'hFFFF_FFFF;
      e = int'(m_env / 65536);
      case (m_state)
         M_CLOSED: if (e >= m_open) m_state = M_OPEN;
         M_OPEN:   if (e < m_close) begin m_state = M_HANG; m_hang = m_hlen; end
         default: begin
            if (e >= m_close) m_state = M_OPEN;
            else if (m_hang == 0) m_state = M_CLOSED;
            else m_hang = m_hang - 1;
         end
      endcase
      outv = (m_state == M_CLOSED) ? 0 : (m_out_env ? e : m);
      o16 = outv[15:0];
      b.data = {o16, 16'h0000};
      b.last = last;
      b.open = (m_state != M_CLOSED);
      b.lvl  = e[15:0];
   endtask

   // ---------------- drive helpers (inputs change on the falling edge)
   task automatic do_reset();
      @(negedge ce_clk);
      ce_rst = 1'b1;
      @(negedge ce_clk);
      ce_rst = 1'b0;
      model_reset();
   endtask

   task automatic write_setting(input logic [7:0] addr, input logic [31:0] data);
      @(negedge ce_clk);
      set_stb = 1'b1; set_addr = addr; set_data = data;
      @(negedge ce_clk);
      set_stb = 1'b0;
      model_set(addr, data);
   endtask

   // One beat with o_tready high; returns at the next falling edge with the
   // result registered. Must be entered on a falling edge.
   task automatic send_now(input logic [31:0] data, output beat_t b);
      i_tvalid = 1'b1; i_tdata = data; i_tlast = 1'b0;
      model_step(data, 1'b0, b);
      @(negedge ce_clk);
      i_tvalid = 1'b0;
   endtask

   // Randomised segment with random input gaps and output backpressure.
   task automatic run_random(input int n_beats);
      int    sent = 0, got = 0, cyc = 0;
      bit    pending = 0;
      beat_t b, e;
      logic [15:0] m16;
      while ((sent < n_beats || exp_q.size() > 0 || pending) && cyc < 6000) begin
         @(negedge ce_clk);
         cyc++;
         o_tready = ($urandom_range(0, 3) != 0);
         if (o_tvalid && o_tready) begin
            got++;
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL rand extra beat: got 0x%0h expected none", o_tdata);
            end else begin
               e = exp_q.pop_front();
               check("rand data", o_tdata, e.data);
               check("rand last", o_tlast, e.last);
               check("rand open", squelch_open, e.open);
               check("rand env_level", env_level, e.lvl);
            end
         end
         if (!pending) begin
            if (sent < n_beats && $urandom_range(0, 3) != 0) begin
               if ($urandom_range(0, 9) == 0) m16 = 16'h8000 | 16'($urandom_range(0, 32767));
               else                           m16 = 16'($urandom_range(0, 1200));
               i_tdata  = {m16, 16'($urandom)};
               i_tlast  = ($urandom_range(0, 7) == 0);
               i_tvalid = 1'b1;
               pending  = 1;
            end else begin
               i_tvalid = 1'b0;
            end
         end
         #1;
         if (pending && i_tready) begin
            model_step(i_tdata, i_tlast, b);
            exp_q.push_back(b);
            sent++;
            pending = 0;
         end
      end
      @(negedge ce_clk);
      i_tvalid = 1'b0;
      check("rand segment beats out", got, n_beats);
      check("rand segment leftover", exp_q.size(), 0);
   endtask

   typedef struct {
      logic [15:0] m;
      logic [15:0] exp_out;
      logic        exp_open;
   } vec_t;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t  vecs[17];
      beat_t b;
      logic [15:0] prev;

      ce_rst = 1'b1; set_stb = 0; set_addr = 0; set_data = 0;
      i_tdata = 0; i_tlast = 0; i_tvalid = 0; o_tready = 1'b1;
      model_reset();
      repeat (2) @(negedge ce_clk);
      ce_rst = 1'b0;
      @(negedge ce_clk);

      // ---- reset values
      check("reset o_tvalid", o_tvalid, 0);
      check("reset o_tdata", o_tdata, 0);
      check("reset o_tlast", o_tlast, 0);
      check("reset squelch_open", squelch_open, 0);
      check("reset env_level", env_level, 0);
      check("reset i_tready", i_tready, 1);

      // ---- gating with hysteresis and hang, then HANG recovery
      vecs = '{
         '{16'd50, 16'd0, 1'b0},   '{16'd120, 16'd120, 1'b1}, '{16'd120, 16'd120, 1'b1},
         '{16'd70, 16'd70, 1'b1},  '{16'd70, 16'd70, 1'b1},   '{16'd70, 16'd70, 1'b1},
         '{16'd70, 16'd70, 1'b1},  '{16'd70, 16'd0, 1'b0},
         '{16'd120, 16'd120, 1'b1}, '{16'd70, 16'd70, 1'b1},  '{16'd70, 16'd70, 1'b1},
         '{16'd90, 16'd90, 1'b1},  '{16'd70, 16'd70, 1'b1},   '{16'd70, 16'd70, 1'b1},
         '{16'd70, 16'd70, 1'b1},  '{16'd70, 16'd70, 1'b1},   '{16'd70, 16'd0, 1'b0}
      };
      write_setting(A_OPEN, 32'd100);
      write_setting(A_CLOSE, 32'd80);
      write_setting(A_HANG, 32'd3);
      write_setting(A_CTRL, 32'd0);
      for (int i = 0; i < 17; i++) begin
         send_now({vecs[i].m, 16'h0000}, b);
         check($sformatf("vec%0d data", i), o_tdata, {vecs[i].exp_out, 16'h0000});
         check($sformatf("vec%0d open", i), squelch_open, vecs[i].exp_open);
         check($sformatf("vec%0d valid", i), o_tvalid, 1);
      end

      // ---- alpha_shift = 2 step response
      do_reset();
      write_setting(A_CTRL, 32'd2);
      prev = 16'd0;
      for (int i = 0; i < 40; i++) begin
         send_now(32'h4000_0000, b);
         check($sformatf("alpha2 step%0d env", i), env_level, b.lvl);
         check($sformatf("alpha2 step%0d monotonic", i), env_level >= prev, 1);
         check($sformatf("alpha2 step%0d bound", i), env_level <= 16'h4000, 1);
         if (i == 0) check("alpha2 first", env_level, 16'h1000);
         if (i == 1) check("alpha2 second", env_level, 16'h1C00);
         if (i == 2) check("alpha2 third", env_level, 16'h2500);
         prev = env_level;
      end
      check("alpha2 converged", env_level >= 16'h3FFF, 1);

      // ---- negative clamp and the positive boundary
      do_reset();
      send_now(32'h8000_0000, b);
      check("neg min env", env_level, 0);
      check("neg min data", o_tdata, 0);
      send_now(32'h7FFF_0000, b);
      check("max pos env", env_level, 16'h7FFF);
      check("max pos data", o_tdata, 32'h7FFF_0000);
      send_now(32'hFFFF_0000, b);
      check("neg one env", env_level, 0);
      check("neg one data", o_tdata, 0);

      // ---- envelope output mode
      do_reset();
      write_setting(A_CTRL, 32'h12);
      send_now(32'h4000_1234, b);
      check("out_env data", o_tdata, 32'h1000_0000);
      check("out_env level", env_level, 16'h1000);

      // ---- settings strobe in the same cycle as a beat uses the old value
      do_reset();
      write_setting(A_OPEN, 32'd100);
      write_setting(A_CLOSE, 32'd80);
      @(negedge ce_clk);
      set_stb = 1'b1; set_addr = A_OPEN; set_data = 32'd200;
      send_now(32'h0096_0000, b);
      set_stb = 1'b0;
      model_set(A_OPEN, 32'd200);
      check("coincident strobe data", o_tdata, 32'h0096_0000);
      check("coincident strobe open", squelch_open, 1);

      // ---- asynchronous reset mid-HANG with a held output beat
      do_reset();
      write_setting(A_OPEN, 32'd100);
      write_setting(A_CLOSE, 32'd80);
      write_setting(A_HANG, 32'd3);
      send_now(32'h0078_0000, b);
      send_now(32'h0046_0000, b);
      o_tready = 1'b0;
      @(negedge ce_clk);
      check("stall hold valid", o_tvalid, 1);
      check("stall hold data", o_tdata, 32'h0046_0000);
      check("stall hold open", squelch_open, 1);
      #2 ce_rst = 1'b1;
      #1;
      check("async rst o_tvalid", o_tvalid, 0);
      check("async rst o_tdata", o_tdata, 0);
      check("async rst open", squelch_open, 0);
      check("async rst env_level", env_level, 0);
      @(negedge ce_clk);
      ce_rst = 1'b0;
      model_reset();
      o_tready = 1'b1;
      send_now(32'h00C8_0000, b);
      check("post rst data", o_tdata, 32'h00C8_0000);
      check("post rst open", squelch_open, 1);
      check("post rst env_level", env_level, 16'd200);

      // ---- randomised stream with backpressure against the model
      do_reset();
      for (int s = 0; s < 4; s++) begin
         write_setting(A_OPEN,  32'($urandom_range(200, 900)));
         write_setting(A_CLOSE, 32'($urandom_range(100, 900)));
         write_setting(A_HANG,  32'($urandom_range(0, 6)));
         write_setting(A_CTRL,  {27'd0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 3))});
         run_random(250);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
